// File: rtl/bsg_dff_gatestack_driver_pkg.sv
// rtl/bsg_dff_gatestack_driver_pkg.sv - shared state encoding and counter sizing for the strobe driver
package bsg_dff_gatestack_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Counter holds (phase length - 1), so $clog2 of the longest phase suffices.
  function automatic int ctr_width(input int s, input int p, input int h);
    int m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bsg_dff_gatestack_driver_ctr.sv
// rtl/bsg_dff_gatestack_driver_ctr.sv - loadable down-counter with zero flag, saturating at zero
module bsg_dff_gatestack_driver_ctr #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic [width_p-1:0] count_o,
  output logic               zero_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (count_q != '0)
      count_d = count_q - width_p'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/bsg_dff_gatestack_driver.sv
// rtl/bsg_dff_gatestack_driver.sv - sequences data setup, per-bit strobe pulse and data hold for the bank
module bsg_dff_gatestack_driver
  import bsg_dff_gatestack_driver_pkg::*;
#(
  parameter int width_p        = 16,
  parameter int setup_cycles_p = 1,
  parameter int pulse_cycles_p = 1,
  parameter int hold_cycles_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic [width_p-1:0] mask_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] strobe_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int ctr_w_lp = ctr_width(setup_cycles_p, pulse_cycles_p, hold_cycles_p);

  state_e              state_q, state_d;
  logic [width_p-1:0]  data_q, mask_q, strobe_q;
  logic                busy_q, done_q, done_d;
  logic                ctr_load, ctr_zero, accept;
  logic [ctr_w_lp-1:0] ctr_val, ctr_count;

  assign accept = (state_q == IDLE) && v_i;

  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_val  = '0;
    case (state_q)
      IDLE: if (v_i) begin
        state_d  = SETUP;
        ctr_load = 1'b1;
        ctr_val  = ctr_w_lp'(setup_cycles_p - 1);
      end
      SETUP: if (ctr_zero) begin
        state_d  = PULSE;
        ctr_load = 1'b1;
        ctr_val  = ctr_w_lp'(pulse_cycles_p - 1);
      end
      PULSE: if (ctr_zero) begin
        state_d  = HOLD;
        ctr_load = 1'b1;
        ctr_val  = ctr_w_lp'(hold_cycles_p - 1);
      end
      HOLD: if (ctr_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done is flagged one edge early so it can be a plain flop aligned with the last HOLD cycle.
  always_comb begin
    done_d = 1'b0;
    if (state_d == HOLD)
      done_d = ctr_load ? (hold_cycles_p == 1) : (ctr_count == ctr_w_lp'(1));
  end

  bsg_dff_gatestack_driver_ctr #(.width_p(ctr_w_lp)) u_ctr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .count_o    (ctr_count),
    .zero_o     (ctr_zero)
  );

  // strobe_q feeds bank clocks directly, so it is decoded from state_d and registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      strobe_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (accept) begin
        data_q <= data_i;
        mask_q <= mask_i;
      end
      strobe_q <= (state_d == PULSE) ? mask_q : '0;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign data_o   = data_q;
  assign strobe_o = strobe_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_bsg_dff_gatestack_driver.sv
// tb/tb_bsg_dff_gatestack_driver.sv - scoreboard bench for default and stretched-timing driver instances
module tb_bsg_dff_gatestack_driver;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] strobe;
    logic        busy;
    logic        done;
    logic        ready;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [15:0] din1 = '0, din2 = '0, mask1 = '0, mask2 = '0;
  logic        rdy1, rdy2, busy1, busy2, done1, done2;
  logic [15:0] dout1, dout2, stb1, stb2;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bsg_dff_gatestack_driver u_dut1 (
    .clk_i(clk), .reset_i(reset), .v_i(v1), .data_i(din1), .mask_i(mask1),
    .ready_o(rdy1), .data_o(dout1), .strobe_o(stb1), .busy_o(busy1), .done_o(done1)
  );

  bsg_dff_gatestack_driver #(.width_p(16), .setup_cycles_p(2), .pulse_cycles_p(3), .hold_cycles_p(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .v_i(v2), .data_i(din2), .mask_i(mask2),
    .ready_o(rdy2), .data_o(dout2), .strobe_o(stb2), .busy_o(busy2), .done_o(done2)
  );

  function automatic exp_t observe(input int sel);
    exp_t o;
    if (sel == 0) o = '{data: dout1, strobe: stb1, busy: busy1, done: done1, ready: rdy1};
    else          o = '{data: dout2, strobe: stb2, busy: busy2, done: done2, ready: rdy2};
    return o;
  endfunction

  // Expected trace for the cycles following an accept edge, ending with the first IDLE cycle.
  task automatic push_expect(input int s, input int p, input int h, input logic [15:0] d, input logic [15:0] m);
    for (int k = 1; k <= s + p + h + 1; k++) begin
      exp_t e;
      e.data   = d;
      e.strobe = (k > s && k <= s + p) ? m : 16'h0;
      e.busy   = (k <= s + p + h);
      e.done   = (k == s + p + h);
      e.ready  = (k == s + p + h + 1);
      sb.push_back(e);
    end
  endtask

  task automatic check_cycle(input int sel, input string tag);
    exp_t e, o;
    e = sb.pop_front();
    o = observe(sel);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL %s: got data=%h strobe=%h busy=%b done=%b ready=%b, expected data=%h strobe=%h busy=%b done=%b ready=%b",
               tag, o.data, o.strobe, o.busy, o.done, o.ready, e.data, e.strobe, e.busy, e.done, e.ready);
    end
  endtask

  task automatic drain(input int sel, input string tag);
    while (sb.size() > 0) begin
      @(negedge clk);
      check_cycle(sel, tag);
    end
  endtask

  // Raises v at a negedge once ready is seen, then returns right after the accept edge.
  task automatic do_accept(input int sel, input logic [15:0] d, input logic [15:0] m, input string tag);
    int waited = 0;
    @(negedge clk);
    while (observe(sel).ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (waited >= 50) begin
      miscompares++;
      $display("FAIL %s_ready_timeout: ready stayed %b, expected 1", tag, observe(sel).ready);
    end
    if (sel == 0) begin v1 = 1'b1; din1 = d; mask1 = m; end
    else          begin v2 = 1'b1; din2 = d; mask2 = m; end
    @(posedge clk);
  endtask

  task automatic release_and_drain(input int sel, input string tag);
    @(negedge clk);
    if (sel == 0) v1 = 1'b0; else v2 = 1'b0;
    check_cycle(sel, tag);
    drain(sel, tag);
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    e = '{data: 16'h0, strobe: 16'h0, busy: 1'b0, done: 1'b0, ready: 1'b1};
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (observe(s) !== e) begin
        miscompares++;
        $display("FAIL reset_idle_dut%0d: got %h, expected %h", s, observe(s), e);
      end
    end
  endtask

  task automatic test_basic;
    do_accept(0, 16'hA5A5, 16'hFFFF, "basic");
    push_expect(1, 1, 1, 16'hA5A5, 16'hFFFF);
    release_and_drain(0, "basic");
  endtask

  task automatic test_stretched;
    do_accept(1, 16'h00F0, 16'h0081, "stretched");
    push_expect(2, 3, 2, 16'h00F0, 16'h0081);
    release_and_drain(1, "stretched");
  endtask

  task automatic test_back_to_back;
    do_accept(0, 16'h1234, 16'h00FF, "b2b_first");
    push_expect(1, 1, 1, 16'h1234, 16'h00FF);
    @(negedge clk);
    din1 = 16'hCAFE;
    mask1 = 16'hF00F;
    check_cycle(0, "b2b_first");
    drain(0, "b2b_first");
    @(posedge clk);
    push_expect(1, 1, 1, 16'hCAFE, 16'hF00F);
    release_and_drain(0, "b2b_second");
  endtask

  task automatic test_mask_zero;
    do_accept(0, 16'h5A5A, 16'h0000, "mask_zero");
    push_expect(1, 1, 1, 16'h5A5A, 16'h0000);
    release_and_drain(0, "mask_zero");
  endtask

  task automatic test_reset_mid_pulse;
    exp_t o, e;
    do_accept(0, 16'hBEEF, 16'hFFFF, "abort");
    push_expect(1, 1, 1, 16'hBEEF, 16'hFFFF);
    @(negedge clk);
    v1 = 1'b0;
    check_cycle(0, "abort_setup");
    @(negedge clk);
    check_cycle(0, "abort_pulse");
    sb.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    o = observe(0);
    e = '{data: 16'h0, strobe: 16'h0, busy: 1'b0, done: 1'b0, ready: 1'b1};
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL abort_reset_edge: got %h, expected %h", o, e);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      o = observe(0);
      vectors++;
      if (o.done !== 1'b0 || o.ready !== 1'b1 || o.strobe !== 16'h0) begin
        miscompares++;
        $display("FAIL abort_after_release: done=%b ready=%b strobe=%h, expected done=0 ready=1 strobe=0000",
                 o.done, o.ready, o.strobe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stretched();
    test_back_to_back();
    test_mask_zero();
    test_reset_mid_pulse();
    test_basic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
